// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, one stop bit.
// Define UART_TX_HOLD_EN to add a one-entry hold register for back-to-back frames.
module uart_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
`ifdef UART_TX_HOLD_EN
    output logic                  o_hold_full,
`endif
    output logic                  o_tx,
    output logic                  o_busy
);

    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    // Source of the next frame: the hold register when occupied, else the input port.
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_par_en;
    logic                  src_par_typ;
    logic                  src_avail;

`ifdef UART_TX_HOLD_EN
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_par_en_q, hold_par_en_d;
    logic                  hold_par_typ_q, hold_par_typ_d;
    logic                  hold_full_q, hold_full_d;

    assign src_data    = hold_full_q ? hold_data_q : i_data;
    assign src_par_en  = hold_full_q ? hold_par_en_q : i_par_en;
    assign src_par_typ = hold_full_q ? hold_par_typ_q : i_par_typ;
    assign src_avail   = hold_full_q | i_data_valid;
    assign o_hold_full = hold_full_q;
`else
    assign src_data    = i_data;
    assign src_par_en  = i_par_en;
    assign src_par_typ = i_par_typ;
    assign src_avail   = i_data_valid;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_HOLD_EN
            hold_data_q    <= '0;
            hold_par_en_q  <= 1'b0;
            hold_par_typ_q <= 1'b0;
            hold_full_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef UART_TX_HOLD_EN
            hold_data_q    <= hold_data_d;
            hold_par_en_q  <= hold_par_en_d;
            hold_par_typ_q <= hold_par_typ_d;
            hold_full_q    <= hold_full_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`ifdef UART_TX_HOLD_EN
        hold_data_d    = hold_data_q;
        hold_par_en_d  = hold_par_en_q;
        hold_par_typ_d = hold_par_typ_q;
        hold_full_d    = hold_full_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (src_avail) begin
                    data_d    = src_data;
                    par_en_d  = src_par_en;
                    par_bit_d = (^src_data) ^ src_par_typ;
                    state_d   = StStart;
`ifdef UART_TX_HOLD_EN
                    hold_full_d = 1'b0;
`endif
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StData;
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? StParity : StStop;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StParity: state_d = StStop;
            StStop: begin
                state_d = StIdle;
`ifdef UART_TX_HOLD_EN
                if (hold_full_q) begin
                    data_d      = hold_data_q;
                    par_en_d    = hold_par_en_q;
                    par_bit_d   = (^hold_data_q) ^ hold_par_typ_q;
                    hold_full_d = 1'b0;
                    state_d     = StStart;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
`ifdef UART_TX_HOLD_EN
        if (state_q != StIdle && i_data_valid && !hold_full_q) begin
            hold_data_d    = i_data;
            hold_par_en_d  = i_par_en;
            hold_par_typ_d = i_par_typ;
            hold_full_d    = 1'b1;
        end
`endif
    end

    // Line outputs are registered from the current state, so they trail it by one cycle.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_q != StIdle);
        unique case (state_q)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = data_q[cnt_q];
            StParity: tx_d = par_bit_q;
            default:  tx_d = 1'b1;
        endcase
    end

    assign o_tx   = tx_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: stimulus queues expected line bits and start cycles,
// a negedge monitor pops and compares whenever a frame is on the line.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       pen;
    logic       ptyp;
    logic       tx;
    logic       busy;
`ifdef UART_TX_HOLD_EN
    logic       hold_full;
`endif

    uart_tx_serializer #(.DATA_WIDTH(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_data      (data),
        .i_data_valid(valid),
        .i_par_en    (pen),
        .i_par_typ   (ptyp),
`ifdef UART_TX_HOLD_EN
        .o_hold_full (hold_full),
`endif
        .o_tx        (tx),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic tx;
        logic last;
    } exp_t;

    exp_t exp_q[$];
    int   rise_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    bit   prev_busy = 1'b0;
    bit   last_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bits are given first-on-the-line in the MSB position.
    task automatic push_frame(input logic [15:0] bits, input int len, input bit mark_last);
        for (int i = len - 1; i >= 0; i--) begin
            exp_t e;
            e.tx   = bits[i];
            e.last = mark_last && (i == 0);
            exp_q.push_back(e);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the acceptance edge.
    task automatic send(input logic [7:0] d, input logic p_en, input logic p_typ,
                        input logic [15:0] frame, input int len);
        data  = d;
        pen   = p_en;
        ptyp  = p_typ;
        valid = 1'b1;
        rise_q.push_back(cyc + 2);
        push_frame(frame, len, 1'b1);
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (busy === 1'b1) begin
                if (!prev_busy) begin
                    if (rise_q.size() == 0) check("unexpected_start", busy, 0);
                    else check("start_cycle", cyc, rise_q.pop_front());
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_busy", busy, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("tx_bit", tx, e.tx);
                    last_seen = e.last;
                end
            end else begin
                check("idle_tx", tx, 1);
                if (prev_busy) check("frame_end", last_seen, 1);
            end
            prev_busy = (busy === 1'b1);
        end
    end

    initial begin
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'hA5;
        pen   = 1'b0;
        ptyp  = 1'b0;
        @(posedge clk);
        #1 mon_en = 1'b1;
        repeat (2) @(posedge clk);
        // Release reset with valid still high: the first clean edge accepts 0xA5.
        #1 rst = 1'b0;
        rise_q.push_back(cyc + 2);
        push_frame(16'b0101001011, 10, 1'b1);
        @(posedge clk);
        #1 valid = 1'b0;
        idle(10);

        send(8'hA5, 1'b1, 1'b0, 16'b01010010101, 11);
        idle(11);
        send(8'hA5, 1'b1, 1'b1, 16'b01010010111, 11);
        idle(11);
        send(8'h07, 1'b1, 1'b0, 16'b01110000011, 11);
        idle(11);

        // Inputs changed after the start bit must not alter the frame.
        send(8'h07, 1'b1, 1'b0, 16'b01110000011, 11);
        idle(2);
        ptyp = 1'b1;
        data = 8'hFF;
        idle(9);
        ptyp = 1'b0;

`ifndef UART_TX_HOLD_EN
        // Valid held across a frame: second word starts after one idle cycle.
        data  = 8'h5A;
        pen   = 1'b0;
        valid = 1'b1;
        rise_q.push_back(cyc + 2);
        push_frame(16'b0010110101, 10, 1'b1);
        rise_q.push_back(cyc + 13);
        push_frame(16'b0110000111, 10, 1'b1);
        @(posedge clk);
        #1 data = 8'hC3;
        repeat (11) @(posedge clk);
        #1 valid = 1'b0;
        idle(10);
`endif

        // Reset during data bit 3 aborts the frame on the next edge.
        send(8'hA5, 1'b0, 1'b0, 16'b01010, 5);
        idle(5);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        send(8'h3C, 1'b0, 1'b0, 16'b0001111001, 10);
        idle(10);

`ifdef UART_TX_HOLD_EN
        // Held word follows the first stop bit with no idle gap.
        data  = 8'hA5;
        pen   = 1'b0;
        ptyp  = 1'b0;
        valid = 1'b1;
        rise_q.push_back(cyc + 2);
        push_frame(16'b0101001011, 10, 1'b0);
        push_frame(16'b0001111001, 10, 1'b1);
        @(posedge clk);
        #1 valid = 1'b0;
        idle(3);
        check("hold_empty_before", hold_full, 0);
        data  = 8'h3C;
        valid = 1'b1;
        idle(1);
        valid = 1'b0;
        check("hold_full_set", hold_full, 1);
        idle(20);
        check("hold_full_clear", hold_full, 0);
`endif

        idle(5);
        check("exp_drained", exp_q.size(), 0);
        check("starts_drained", rise_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
